bid_collector: RTL
==================

# bid_collector

Sequential front end for the combinational max-bid auction tree. It accepts one bid per cycle from 2**N bidders over a valid/ready channel and stores each bid by bidder ID. It closes the round when every bidder has bid or `close` is asserted, then presents the packed bid vector, bidder-0 bid in the LSBs, to the auction stage. It holds that vector until the consumer acknowledges it, then starts a fresh round.

## Interface
- `N`, 2, log2 of bidder count; also the bidder-ID width.
- `W`, 2, bid width in bits.
- `R`, 8, round-counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `bid_valid`  in  1  the upstream side is offering a bid.
- `bid_ready`  out  1  the block can accept a bid.
- `bid_id`  in  N  bidder index.
- `bid_value`  in  W  bid amount, unsigned.
- `close`  in  1  close the current round early; bidders that have not bid count as 0.
- `bid`  out  (2**N)*W  packed bid vector; slice i is `[(i+1)*W-1:i*W]`.
- `bid_mask`  out  2**N  bit i = 1 means bidder i bid this round.
- `out_valid`  out  1  `bid` and `bid_mask` are complete and stable.
- `out_ready`  in  1  the auction consumer accepts the vector.
- `dup_err`  out  1  one-cycle pulse: a duplicate bid was accepted and discarded.
- `round`  out  R  number of completed rounds, wrapping at 2**R.

## Operation
- Two states.
  - COLLECT: `bid_ready`=1, `out_valid`=0.
  - PRESENT: `bid_ready`=0, `out_valid`=1.
- Reset (`rst`=0 at an edge) forces the following, regardless of state:
  - state=COLLECT;
  - every bid slot=0 and `bid_mask`=0;
  - `dup_err`=0 and `round`=0.
- Reset mid-round discards all collected bids. Reset during PRESENT drops the vector without counting a round.
- Accept: `bid_valid` & `bid_ready` at an edge.
- If `bid_mask[bid_id]`=0:
  - slot `bid_id` gets `bid_value`;
  - `bid_mask[bid_id]` is set to 1.
- If `bid_mask[bid_id]`=1, the first bid wins:
  - the new value is discarded;
  - the slot is unchanged;
  - `dup_err`=1 for the following cycle only.
- COLLECT → PRESENT happens at the edge where either condition holds:
  - (a) the mask after the update is all ones;
  - (b) `close`=1.
- If `close` and an accept occur at the same edge, the bid is stored first and is included in the presented vector.
- `close` with zero bids still enters PRESENT, with all-zero `bid` and `bid_mask`.
- In PRESENT:
  - `bid` and `bid_mask` are held constant;
  - `close` and `bid_valid` are ignored; no accept can occur because `bid_ready`=0.
- PRESENT → COLLECT at the edge where `out_ready`=1. At that edge:
  - all slots and `bid_mask` are cleared to 0;
  - `round` increments modulo 2**R.
- `out_ready` is ignored in COLLECT.
- Unwritten slots always read 0, so `bid` can feed the auction stage directly.
- All outputs are registered, except `bid_ready` and `out_valid`, which decode directly from the state register.

## Timing
- Accept at edge k makes the slot and mask bit visible in cycle k+1.
- If that accept completes the mask, `out_valid`=1 from cycle k+1.
- Minimum round for 2**N bidders: 2**N accept cycles plus 1 handshake cycle. The edge that leaves PRESENT returns to COLLECT, so `bid_ready`=1 in the next cycle.
- `dup_err` is high during cycle k+1 only, for a duplicate accepted at edge k.
- Back-to-back accepts are sustained at 1 per cycle throughout COLLECT.
- `bid_id` and `bid_value` are don't-care when `bid_valid`=0.

## Test plan
1. N=2, W=2, reset then bids (id, value) = (0,1), (1,3), (2,2), (3,0) on consecutive cycles → `out_valid` rises the cycle after the 4th accept.
   - `bid`=8'b00_10_11_01, `bid_mask`=4'hF.
   - `bid_ready`=0 until `out_ready`.
   - After `out_ready`, `round`=1 and `bid`=0.
2. Bids (2,3) then (2,1) → `dup_err` pulses one cycle after the second accept.
   - Slot 2 stays 3; `bid_mask`=4'b0100.
3. Bid (1,2) with `close`=1 in the same cycle → next cycle `out_valid`=1, `bid`=8'b00_00_10_00, `bid_mask`=4'b0010.
4. Vector presented, `out_ready` held 0 for 5 cycles while `bid_valid`=1 and `close` toggle → `bid`, `bid_mask` and `round` unchanged; `bid_ready`=0 throughout.
5. Reset asserted after 2 of 4 bids → next cycle all outputs are at reset values.
   - A subsequent full round presents only the new bids.
6. With R=2, complete 5 rounds → `round` reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/bid_collector.sv
// bid_collector: gathers one bid per bidder per round and presents the packed bid vector
module bid_collector #(
  parameter int N = 2,
  parameter int W = 2,
  parameter int R = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bid_valid,
  output logic                 bid_ready,
  input  logic [N-1:0]         bid_id,
  input  logic [W-1:0]         bid_value,
  input  logic                 close,
  output logic [(2**N)*W-1:0]  bid,
  output logic [2**N-1:0]      bid_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 dup_err,
  output logic [R-1:0]         round
);
  localparam int B = 2**N;
  typedef enum logic {COLLECT, PRESENT} state_t;
  state_t state, state_nxt;
  logic accept, dup;
  logic [B-1:0] mask_nxt;
  logic [B*W-1:0] bid_nxt;
  assign bid_ready = state == COLLECT;
  assign out_valid = state == PRESENT;
  // first bid per bidder wins; the round closes on a full mask or an early close
  always_comb begin
    accept = bid_valid & bid_ready;
    dup = accept & bid_mask[bid_id];
    mask_nxt = bid_mask;
    bid_nxt = bid;
    if (accept && !bid_mask[bid_id]) begin
      mask_nxt[bid_id] = 1'b1;
      bid_nxt[bid_id*W +: W] = bid_value;
    end
    state_nxt = state == COLLECT ? ((&mask_nxt || close) ? PRESENT : COLLECT)
                                 : (out_ready ? COLLECT : PRESENT);
  end
  // state, slots and round counter; the handshake out of PRESENT clears the slots for a fresh round
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= COLLECT;
      bid <= '0;
      bid_mask <= '0;
      dup_err <= 1'b0;
      round <= '0;
    end else begin
      state <= state_nxt;
      dup_err <= dup;
      if (state == PRESENT) begin
        if (out_ready) begin
          bid <= '0;
          bid_mask <= '0;
          round <= round + 1'b1;
        end
      end else begin
        bid <= bid_nxt;
        bid_mask <= mask_nxt;
      end
    end
  end
endmodule
